timer_input_filter: RTL
=======================

# timer_input_filter

Per-channel input conditioner that sits directly upstream of the general timer's external-measurement and capture inputs. Each asynchronous pin is synchronized (two flops), glitch-filtered by a programmable stability counter, and edge-detected. The block drives a clean level (to `ext_meas_i`) and a one-cycle edge pulse (to `capture_i`). Rejected glitches are flagged for status/debug.

## Interface
Parameters:
- `CH`, 2, number of independent input channels
- `FILT_W`, 4, width of the filter length / stability counter

Ports:
- `clk`  input  1  sole clock; all state on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `en_i`  input  1  filter enable (common to all channels)
- `filt_len_i`  input  FILT_W  extra stable cycles required before a change is accepted (0 = accept after 1 sample)
- `edge_sel_i`  input  2*CH  per channel [2c+1:2c]: 00 none, 01 rising, 10 falling, 11 both
- `in_async_i`  input  CH  raw asynchronous pins
- `level_o`  output  CH  filtered level (feeds timer `ext_meas_i`)
- `pulse_o`  output  CH  one-cycle pulse on selected accepted edge (feeds timer `capture_i`)
- `glitch_o`  output  CH  one-cycle pulse when a pending change is rejected

## Operation
- Per channel: sync chain `s1 <= in_async_i[c]`, `s2 <= s1`, always running, including when `en_i=0`.
- State per channel: `level` (drives `level_o`), `cnt` (FILT_W bits), registered `pulse`, registered `glitch`.
- `en_i=0`: `level <= s2`, `cnt <= 0`, `pulse <= 0`, `glitch <= 0`. Level tracks silently, so enabling never produces a spurious edge.
- `en_i=1`, evaluated each cycle:
  - IDLE (`s2 == level`): if `cnt != 0`, `glitch <= 1`. Then `cnt <= 0`.
  - PENDING (`s2 != level`, `cnt < filt_len_i`): `cnt <= cnt + 1`.
  - ACCEPT (`s2 != level`, `cnt >= filt_len_i`): `level <= s2`, `cnt <= 0`. `pulse <= 1` if the edge matches `edge_sel_i` (rising = new level 1, falling = new level 0).
- `pulse` and `glitch` otherwise default to 0; each is high for exactly one cycle per event.
- `cnt` never exceeds `filt_len_i`. If `filt_len_i` is lowered while pending with `cnt >= new value`, the change is accepted on the next cycle. Raising `filt_len_i` extends the current pending count. No wrap is possible.
- `edge_sel_i` = 00: `level_o` still updates, `pulse_o` stays 0.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset (async assert, sync use after deassert): `s1`, `s2`, `level_o`, `pulse_o`, `glitch_o`, `cnt` all 0.
- Latency, pin change to `level_o`/`pulse_o`, with the pin stable: 2 sync cycles + (`filt_len_i` + 1) cycles.
  - `filt_len_i=0`: the outputs update on the 3rd rising edge after the pin change is first sampled.
- Minimum accepted pulse width: `filt_len_i + 1` cycles at `s2`. Anything shorter is rejected, and `glitch_o` fires the cycle after `s2` returns.
- A single-cycle `s2` excursion with `filt_len_i=0` is accepted, not flagged.
- `pulse_o` is asserted in the same cycle `level_o` first shows the new value.
- `en_i` deassert mid-pending: the count is discarded next cycle, with no `glitch_o`.
- Reset mid-pending: all state cleared immediately, with no pulse.

## Test plan
- Reset: drive `in_async_i=2'b11` with `rst_n=0`. All outputs stay 0. Release reset with `en_i=1`, `filt_len_i=3`, `edge_sel_i=4'b0101`. Required: `level_o=2'b11` and `pulse_o=2'b11` for one cycle, exactly 6 cycles after the first post-reset edge.
- Filtering: `filt_len_i=3`, ch0 rising, pin high for 3 cycles then low. Required: no `level_o`/`pulse_o` change, and `glitch_o[0]` pulses once. Repeat with 4 cycles high. Required: `level_o[0]=1` and `pulse_o[0]` one cycle, then a falling change accepted with no pulse (edge_sel=01).
- Edge select: ch1 with `edge_sel=11`, `filt_len_i=0`, pin toggles every 5 cycles. Required: `pulse_o[1]` on every toggle, each 3 cycles after the pin edge. With `edge_sel=10`, pulses occur only on falls. With `00`, no pulses while `level_o` still follows.
- Enable: `en_i=0`, pin goes high. Required: `level_o` follows after 3 cycles with `pulse_o=0`. Then `en_i=1`. Required: no pulse.
- Dynamic length: `filt_len_i=10`, pin high, after `cnt` reaches 6 set `filt_len_i=2`. Required: accepted on the next cycle, with one `pulse_o`.
- Independence: toggle ch0 and ch1 on the same cycle with equal settings. Required: identical simultaneous `pulse_o=2'b11`.

Source files
------------

// File: rtl/timer_input_filter.sv
// Per-channel input conditioner for the general timer: two-flop synchronizer,
// programmable stability filter, and edge-selectable capture pulse with glitch flag.
module timer_input_filter #(
    parameter int CH     = 2,
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic [2*CH-1:0]   edge_sel_i,
    input  logic [CH-1:0]     in_async_i,
    output logic [CH-1:0]     level_o,
    output logic [CH-1:0]     pulse_o,
    output logic [CH-1:0]     glitch_o
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic              s1;
        logic              s2;
        logic              level;
        logic              pulse;
        logic              glitch;
        logic [FILT_W-1:0] cnt;
        logic              differs;
        logic              accept;
        logic              edge_hit;

        // The synchronized sample has disagreed with the filtered level long enough
        // once cnt reaches the length; >= makes a lowered length take effect at once.
        always_comb begin
            differs  = (s2 != level);
            accept   = differs && (cnt >= filt_len_i);
            edge_hit = s2 ? edge_sel_i[2*c] : edge_sel_i[2*c+1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= in_async_i[c];
                s2 <= s1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level  <= 1'b0;
                cnt    <= '0;
                pulse  <= 1'b0;
                glitch <= 1'b0;
            end else begin
                pulse  <= 1'b0;
                glitch <= 1'b0;
                if (!en_i) begin
                    // Track silently so that enabling later cannot create an edge.
                    level <= s2;
                    cnt   <= '0;
                end else if (!differs) begin
                    glitch <= (cnt != '0);
                    cnt    <= '0;
                end else if (accept) begin
                    level <= s2;
                    cnt   <= '0;
                    pulse <= edge_hit;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level_o[c]  = level;
        assign pulse_o[c]  = pulse;
        assign glitch_o[c] = glitch;
    end

endmodule
